// File: rtl/bus_arb.sv
// bus_arb: fixed-priority six-master bus arbiter with turnaround cycles.
// Define BUS_ARB_PREEMPT_EN to compile in the hold counter and preempt request.
module bus_arb #(
  parameter int HOLD_MAX = 64,
  parameter int TURN_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] req,
  output logic [5:0] gnt,
  output logic [2:0] owner,
  output logic       bus_idle,
  output logic       preempt
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("bus_arb: HOLD_MAX must be 1..255");
  end
  if (TURN_CYC < 0 || TURN_CYC > 3) begin : g_bad_turn
    $error("bus_arb: TURN_CYC must be 0..3");
  end

  localparam logic [1:0] TURN_LOAD =
    (TURN_CYC > 0) ? 2'(TURN_CYC - 1) : 2'd0;
  localparam logic [2:0] NO_OWNER = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] gnt_q, gnt_d;
  logic [2:0] owner_q, owner_d;
  logic       bus_idle_q, bus_idle_d;
  logic [1:0] turn_q, turn_d;
  logic [2:0] arb;
  logic [5:0] cand;

`ifdef BUS_ARB_PREEMPT_EN
  logic [7:0] hold_q, hold_d;
  logic       preempt_q, preempt_d;
  logic       hi_req;
`endif

  function automatic logic [2:0] pick(input logic [5:0] r);
    logic [2:0] idx;
    priority case (1'b1)
      r[5]:    idx = 3'd5;
      r[4]:    idx = 3'd4;
      r[3]:    idx = 3'd3;
      r[2]:    idx = 3'd2;
      r[1]:    idx = 3'd1;
      r[0]:    idx = 3'd0;
      default: idx = NO_OWNER;
    endcase
    return idx;
  endfunction

  function automatic logic [5:0] onehot(input logic [2:0] idx);
    return (idx < 3'd6) ? (6'd1 << idx) : 6'd0;
  endfunction

  // Released owner's bit is masked so it cannot win the release cycle.
  always_comb begin
    cand = req & ~gnt_q;
    arb  = pick(cand);
  end

`ifdef BUS_ARB_PREEMPT_EN
  // Any request strictly above the current owner.
  always_comb begin
    hi_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > int'(owner_q)) hi_req = hi_req | req[i];
    end
  end
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    bus_idle_d = bus_idle_q;
    turn_d     = turn_q;
`ifdef BUS_ARB_PREEMPT_EN
    hold_d     = hold_q;
    preempt_d  = preempt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = GRANT;
          gnt_d      = onehot(arb);
          owner_d    = arb;
          bus_idle_d = 1'b0;
`ifdef BUS_ARB_PREEMPT_EN
          hold_d     = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (|(req & gnt_q)) begin
`ifdef BUS_ARB_PREEMPT_EN
          if (hold_q != 8'hff) hold_d = hold_q + 8'd1;
          if (hold_q >= 8'(HOLD_MAX) && hi_req &&
              owner_q != 3'd5)
            preempt_d = 1'b1;
`endif
        end else begin
          gnt_d   = 6'd0;
          owner_d = NO_OWNER;
`ifdef BUS_ARB_PREEMPT_EN
          preempt_d = 1'b0;
`endif
          if (TURN_CYC > 0) begin
            state_d = TURN;
            turn_d  = TURN_LOAD;
          end else if (|cand) begin
            gnt_d   = onehot(arb);
            owner_d = arb;
`ifdef BUS_ARB_PREEMPT_EN
            hold_d  = 8'd0;
`endif
          end else begin
            state_d    = IDLE;
            bus_idle_d = 1'b1;
          end
        end
      end
      TURN: begin
        if (turn_q != 2'd0) begin
          turn_d = turn_q - 2'd1;
        end else if (|req) begin
          state_d = GRANT;
          gnt_d   = onehot(arb);
          owner_d = arb;
`ifdef BUS_ARB_PREEMPT_EN
          hold_d  = 8'd0;
`endif
        end else begin
          state_d    = IDLE;
          bus_idle_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = 6'd0;
        owner_d    = NO_OWNER;
        bus_idle_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 6'd0;
      owner_q    <= NO_OWNER;
      bus_idle_q <= 1'b1;
      turn_q     <= 2'd0;
`ifdef BUS_ARB_PREEMPT_EN
      hold_q     <= 8'd0;
      preempt_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      bus_idle_q <= bus_idle_d;
      turn_q     <= turn_d;
`ifdef BUS_ARB_PREEMPT_EN
      hold_q     <= hold_d;
      preempt_q  <= preempt_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign bus_idle = bus_idle_q;
`ifdef BUS_ARB_PREEMPT_EN
  assign preempt  = preempt_q;
`else
  assign preempt  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: directed stimulus with a queued expectation scoreboard.
// Covers TURN_CYC=1 and TURN_CYC=0 instances side by side.
module tb_bus_arb;

  logic       clk = 1'b0;
  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic [5:0] req0 = 6'd0, req1 = 6'd0;
  logic [5:0] gnt0, gnt1;
  logic [2:0] own0, own1;
  logic       idl0, idl1, pre0, pre1;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

`ifdef BUS_ARB_PREEMPT_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  typedef struct {
    int         due;
    int         d;
    logic [5:0] g;
    logic [2:0] o;
    logic       i;
    logic       p;
    string      tag;
  } exp_t;

  exp_t sb[$];

  bus_arb #(.HOLD_MAX(4), .TURN_CYC(1)) u0 (
    .clk(clk), .reset(rst0), .req(req0), .gnt(gnt0),
    .owner(own0), .bus_idle(idl0), .preempt(pre0)
  );

  bus_arb #(.HOLD_MAX(4), .TURN_CYC(0)) u1 (
    .clk(clk), .reset(rst1), .req(req1), .gnt(gnt1),
    .owner(own1), .bus_idle(idl1), .preempt(pre1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare outputs due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic [5:0] g;
      logic [2:0] o;
      logic i, p;
      e = sb.pop_front();
      g = (e.d == 0) ? gnt0 : gnt1;
      o = (e.d == 0) ? own0 : own1;
      i = (e.d == 0) ? idl0 : idl1;
      p = (e.d == 0) ? pre0 : pre1;
      n_run++;
      if (e.due != cyc || g !== e.g || o !== e.o ||
          i !== e.i || p !== e.p) begin
        n_fail++;
        $display("FAIL %s dut%0d cyc%0d: got g=%b o=%0d i=%b p=%b want g=%b o=%0d i=%b p=%b",
                 e.tag, e.d, cyc, g, o, i, p, e.g, e.o, e.i, e.p);
      end
    end
  end

  // One cycle of stimulus on DUT d plus expected outputs after the edge.
  task automatic step(input int d, input logic rs, input logic [5:0] r,
                      input logic [5:0] eg, input logic [2:0] eo,
                      input logic ei, input logic ep, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (d == 0) begin rst0 = rs; req0 = r; end
    else        begin rst1 = rs; req1 = r; end
    e.due = cyc + 1;
    e.d = d; e.g = eg; e.o = eo; e.i = ei; e.p = ep;
    e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin
    // TURN_CYC=1 instance
    step(0, 1, 6'b000000, 6'b000000, 7, 1, 0, "reset");
    step(0, 0, 6'b000101, 6'b000100, 2, 0, 0, "first_grant");
    step(0, 0, 6'b000101, 6'b000100, 2, 0, 0, "hold_gpu");
    step(0, 0, 6'b000001, 6'b000000, 7, 0, 0, "turn");
    step(0, 0, 6'b000001, 6'b000001, 0, 0, 0, "grant_cpu");
    step(0, 0, 6'b000101, 6'b000001, 0, 0, 0, "no_steal");
    step(0, 0, 6'b000100, 6'b000000, 7, 0, 0, "turn2");
    step(0, 0, 6'b000000, 6'b000000, 7, 1, 0, "to_idle");
    step(0, 0, 6'b001010, 6'b001000, 3, 0, 0, "grant_b1");
    step(0, 0, 6'b001010, 6'b001000, 3, 0, 0, "hold_b1");
    step(0, 0, 6'b111111, 6'b001000, 3, 0, 0, "hold_all");
    step(0, 1, 6'b111111, 6'b000000, 7, 1, 0, "rst_mid");
    step(0, 1, 6'b111111, 6'b000000, 7, 1, 0, "rst_hold");
    step(0, 0, 6'b111111, 6'b100000, 5, 0, 0, "rst_resume");
    for (int k = 0; k < 300; k++)
      step(0, 0, 6'b110000, 6'b100000, 5, 0, 0, "refresh_long");
    step(0, 0, 6'b010000, 6'b000000, 7, 0, 0, "rf_release");
    step(0, 0, 6'b010000, 6'b010000, 4, 0, 0, "grant_obj");
    step(0, 0, 6'b000000, 6'b000000, 7, 0, 0, "obj_release");
    step(0, 0, 6'b000000, 6'b000000, 7, 1, 0, "idle2");
    step(0, 0, 6'b000001, 6'b000001, 0, 0, 0, "cpu_h0");
    step(0, 0, 6'b000001, 6'b000001, 0, 0, 0, "cpu_h1");
    step(0, 0, 6'b100001, 6'b000001, 0, 0, 0, "cpu_h2");
    step(0, 0, 6'b100001, 6'b000001, 0, 0, 0, "cpu_h3");
    step(0, 0, 6'b100001, 6'b000001, 0, 0, 0, "cpu_h4");
    step(0, 0, 6'b100001, 6'b000001, 0, 0, PE, "preempt_on");
    step(0, 0, 6'b100001, 6'b000001, 0, 0, PE, "preempt_held");
    step(0, 0, 6'b100000, 6'b000000, 7, 0, 0, "preempt_clr");
    step(0, 0, 6'b100000, 6'b100000, 5, 0, 0, "grant_rf");
    // TURN_CYC=0 instance
    step(1, 1, 6'b000000, 6'b000000, 7, 1, 0, "t0_reset");
    step(1, 0, 6'b001000, 6'b001000, 3, 0, 0, "t0_grant_b1");
    step(1, 0, 6'b011010, 6'b001000, 3, 0, 0, "t0_hold");
    step(1, 0, 6'b010010, 6'b010000, 4, 0, 0, "t0_no_dead");
    step(1, 0, 6'b000010, 6'b000010, 1, 0, 0, "t0_next");
    step(1, 0, 6'b000000, 6'b000000, 7, 1, 0, "t0_idle");
    step(1, 0, 6'b000000, 6'b000000, 7, 1, 0, "t0_stay");
    repeat (4) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
